// File: rtl/dds_phase_accumulator.sv
// dds_phase_accumulator
//   NCO front end of the DDS chain. Accumulates a frequency tuning word (FTW)
//   on every enabled clock and adds a phase offset. The top ADDR_WIDTH bits of
//   the result drive the sine-ROM address. FTW and offset writes go to shadow
//   registers and are committed on an accumulator wrap, which keeps the phase
//   continuous. A linear sweep engine steps the FTW towards a stop value.
//
// Ports
//   clock, reset_n         : clock and synchronous active-low reset
//   enable                 : 1 = accumulate, 0 = hold phase
//   cfg_valid/ready/sel/data: config writes (0=FTW, 1=offset, 2=step, 3=stop)
//   sweep_start, sweep_dwell: start pulse and enabled cycles per sweep step
//   addr, addr_valid       : ROM address and its qualifier
//   wrap                   : one-cycle pulse on accumulator carry-out
//   sweep_busy, sweep_done : sweep in progress / one-cycle completion pulse
module dds_phase_accumulator #(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 11,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [1:0]             cfg_sel,
    input  logic [PHASE_WIDTH-1:0] cfg_data,
    input  logic                   sweep_start,
    input  logic [DWELL_WIDTH-1:0] sweep_dwell,
    output logic [ADDR_WIDTH-1:0]  addr,
    output logic                   addr_valid,
    output logic                   wrap,
    output logic                   sweep_busy,
    output logic                   sweep_done
);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t                 state;
    logic [PHASE_WIDTH-1:0] phase_acc;
    logic [PHASE_WIDTH-1:0] ftw_active, ftw_shadow;
    logic [PHASE_WIDTH-1:0] offset_active, offset_shadow;
    logic [PHASE_WIDTH-1:0] step, stop;
    logic                   ftw_pend, offset_pend;
    logic [DWELL_WIDTH-1:0] dwell_cnt;

    logic [PHASE_WIDTH:0]   acc_sum;
    logic [PHASE_WIDTH-1:0] addr_sum;
    logic [PHASE_WIDTH:0]   sweep_next;
    logic [DWELL_WIDTH-1:0] dwell_last;
    logic                   commit, cfg_fire, start_ok, dwell_hit, sweep_end;

    assign acc_sum  = {1'b0, phase_acc} + {1'b0, ftw_active};
    assign addr_sum = phase_acc + offset_active;
    // Shadows move to active on the wrap edge, or at once while holding.
    assign commit   = !enable || acc_sum[PHASE_WIDTH];
    assign cfg_fire = cfg_valid && cfg_ready;
    assign start_ok = (state == IDLE) && sweep_start && (step != '0);

    // A dwell of 0 behaves as 1. Using >= keeps the counter from running
    // away if sweep_dwell is lowered mid-sweep.
    assign dwell_last = (sweep_dwell == '0) ? '0 : sweep_dwell - DWELL_WIDTH'(1);
    assign dwell_hit  = dwell_cnt >= dwell_last;
    assign sweep_next = {1'b0, ftw_active} + {1'b0, step};
    assign sweep_end  = sweep_next[PHASE_WIDTH] || (sweep_next[PHASE_WIDTH-1:0] >= stop);

    assign cfg_ready  = (state == IDLE);
    assign sweep_busy = (state == SWEEP);
    assign sweep_done = (state == DONE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            phase_acc     <= '0;
            ftw_active    <= '0;
            ftw_shadow    <= '0;
            offset_active <= '0;
            offset_shadow <= '0;
            step          <= '0;
            stop          <= '0;
            ftw_pend      <= 1'b0;
            offset_pend   <= 1'b0;
            dwell_cnt     <= '0;
            addr          <= '0;
            addr_valid    <= 1'b0;
            wrap          <= 1'b0;
        end else begin
            if (enable) begin
                phase_acc  <= acc_sum[PHASE_WIDTH-1:0];
                wrap       <= acc_sum[PHASE_WIDTH];
                addr       <= addr_sum[PHASE_WIDTH-1 -: ADDR_WIDTH];
                addr_valid <= 1'b1;
            end else begin
                wrap       <= 1'b0;
                addr_valid <= 1'b0;
            end

            if (offset_pend && commit) begin
                offset_active <= offset_shadow;
                offset_pend   <= 1'b0;
            end

            // The sweep engine owns ftw_active outside IDLE, so a pending FTW
            // waits until the sweep has finished.
            if (ftw_pend && (state == IDLE) && (commit || start_ok)) begin
                ftw_active <= ftw_shadow;
                ftw_pend   <= 1'b0;
            end

            // Placed after the commits: a write landing with a commit leaves
            // the new value in shadow with pending still set.
            if (cfg_fire) begin
                case (cfg_sel)
                    2'd0: begin ftw_shadow    <= cfg_data; ftw_pend    <= 1'b1; end
                    2'd1: begin offset_shadow <= cfg_data; offset_pend <= 1'b1; end
                    2'd2: step <= cfg_data;
                    2'd3: stop <= cfg_data;
                endcase
            end

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state     <= SWEEP;
                        dwell_cnt <= '0;
                    end
                end
                SWEEP: begin
                    if (enable) begin
                        if (dwell_hit) begin
                            dwell_cnt <= '0;
                            if (sweep_end) begin
                                ftw_active <= stop;
                                state      <= DONE;
                            end else begin
                                ftw_active <= sweep_next[PHASE_WIDTH-1:0];
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_phase_accumulator.sv
module tb_dds_phase_accumulator;

    logic        clock = 1'b0;
    logic        reset_n, enable, cfg_valid, sweep_start;
    logic [1:0]  cfg_sel;
    logic [31:0] cfg_data;
    logic [15:0] sweep_dwell;
    logic        cfg_ready, addr_valid, wrap, sweep_busy, sweep_done;
    logic [10:0] addr;

    int checks = 0;
    int errors = 0;

    dds_phase_accumulator dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
        .cfg_data(cfg_data), .sweep_start(sweep_start), .sweep_dwell(sweep_dwell),
        .addr(addr), .addr_valid(addr_valid), .wrap(wrap),
        .sweep_busy(sweep_busy), .sweep_done(sweep_done)
    );

    always #5 clock = ~clock;

    logic [15:0] obs;
    assign obs = {addr, addr_valid, wrap, sweep_busy, sweep_done, cfg_ready};

    // Reference model: arithmetic on the described behaviour, one call per edge.
    logic [31:0] m_phase, m_ftw, m_ftw_sh, m_off, m_off_sh, m_step, m_stop;
    bit          m_ftw_p, m_off_p, m_busy, m_done, m_wrap, m_valid;
    logic [10:0] m_addr;
    int unsigned m_cnt;

    function automatic logic [15:0] exp_vec();
        return {m_addr, m_valid, m_wrap, m_busy, m_done, !(m_busy || m_done)};
    endfunction

    function automatic bit wraps_next();
        return (64'(m_phase) + 64'(m_ftw)) >= 64'h1_0000_0000;
    endfunction

    task automatic tick();
        logic [63:0] sum, nxt;
        bit carry, commit, ready, start_ok;
        int unsigned span;
        @(posedge clock);
        if (!reset_n) begin
            m_phase = 0; m_ftw = 0; m_ftw_sh = 0; m_off = 0; m_off_sh = 0;
            m_step = 0; m_stop = 0; m_ftw_p = 0; m_off_p = 0; m_busy = 0;
            m_done = 0; m_wrap = 0; m_valid = 0; m_addr = 0; m_cnt = 0;
        end else begin
            sum      = 64'(m_phase) + 64'(m_ftw);
            carry    = sum >= 64'h1_0000_0000;
            commit   = !enable || carry;
            ready    = !m_busy && !m_done;
            start_ok = ready && sweep_start && (m_step != 0);
            if (enable) begin
                m_addr  = 11'(((64'(m_phase) + 64'(m_off)) % 64'h1_0000_0000) / 64'd2097152);
                m_valid = 1;
                m_wrap  = carry;
                m_phase = 32'(sum % 64'h1_0000_0000);
            end else begin
                m_valid = 0;
                m_wrap  = 0;
            end
            if (m_off_p && commit) begin m_off = m_off_sh; m_off_p = 0; end
            if (m_ftw_p && ready && (commit || start_ok)) begin m_ftw = m_ftw_sh; m_ftw_p = 0; end
            if (m_done) m_done = 0;
            else if (m_busy) begin
                if (enable) begin
                    span = (sweep_dwell == 0) ? 1 : sweep_dwell;
                    if (m_cnt + 1 >= span) begin
                        m_cnt = 0;
                        nxt = 64'(m_ftw) + 64'(m_step);
                        if (nxt >= 64'(m_stop) || nxt >= 64'h1_0000_0000) begin
                            m_ftw = m_stop; m_busy = 0; m_done = 1;
                        end else m_ftw = nxt[31:0];
                    end else m_cnt++;
                end
            end else if (start_ok) begin
                m_busy = 1; m_cnt = 0;
            end
            if (ready && cfg_valid) begin
                case (cfg_sel)
                    2'd0: begin m_ftw_sh = cfg_data; m_ftw_p = 1; end
                    2'd1: begin m_off_sh = cfg_data; m_off_p = 1; end
                    2'd2: m_step = cfg_data;
                    2'd3: m_stop = cfg_data;
                endcase
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n = 0; enable = 0; cfg_valid = 0; sweep_start = 0;
        tick();
        reset_n = 1;
    endtask

    task automatic write_cfg(input logic [1:0] sel, input logic [31:0] data);
        cfg_valid = 1; cfg_sel = sel; cfg_data = data;
        tick();
        cfg_valid = 0;
    endtask

    task automatic test_reset();
        reset_n = 0; enable = 1; cfg_valid = 1; cfg_sel = 2'($urandom);
        cfg_data = $urandom; sweep_start = 1; sweep_dwell = 16'($urandom);
        tick();
        checks++;
        if (obs !== 16'h0001) begin
            errors++; $display("FAIL reset: got %h want %h", obs, 16'h0001);
        end
        reset_n = 1; cfg_valid = 0; sweep_start = 0; enable = 0;
    endtask

    task automatic test_basic();
        int nwrap = 0;
        do_reset();
        write_cfg(0, 32'h0020_0000);
        tick();
        enable = 1;
        tick();
        checks++;
        if ({addr, addr_valid} !== {11'd0, 1'b1}) begin
            errors++; $display("FAIL basic first: got addr %0d v %b want 0 v 1", addr, addr_valid);
        end
        for (int i = 0; i < 2100; i++) begin
            tick();
            if (wrap === 1'b1) nwrap++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL basic cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        checks++;
        if (nwrap != 1) begin
            errors++; $display("FAIL basic wrap count: got %0d want 1", nwrap);
        end
    endtask

    task automatic test_half();
        do_reset();
        write_cfg(0, 32'h8000_0000);
        tick();
        enable = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL half cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        write_cfg(1, 32'h4000_0000);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL half offset cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        checks++;
        if (addr !== 11'd512 && addr !== 11'd1536) begin
            errors++; $display("FAIL half offset addr: got %0d want 512 or 1536", addr);
        end
    endtask

    task automatic test_midrun();
        bit found = 0;
        logic [10:0] a0, d;
        do_reset();
        write_cfg(0, 32'h0020_0000);
        tick();
        enable = 1;
        for (int i = 0; i < int'($urandom_range(50, 500)); i++) tick();
        write_cfg(0, 32'h0040_0000);
        for (int i = 0; i < 2100; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL midrun cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        for (int k = 0; k < 5000 && !found; k++) begin
            if (wraps_next()) found = 1;
            else tick();
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL midrun wrap wait: got timeout want wrap edge");
        end
        write_cfg(0, 32'h0080_0000);
        a0 = addr; tick(); d = addr - a0;
        checks++;
        if (d !== 11'd2) begin
            errors++; $display("FAIL midrun write-on-wrap step: got %0d want 2", d);
        end
        for (int i = 0; i < 1100; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL midrun2 cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        a0 = addr; tick(); d = addr - a0;
        checks++;
        if (d !== 11'd4) begin
            errors++; $display("FAIL midrun late step: got %0d want 4", d);
        end
    endtask

    task automatic test_sweep(input bit stall);
        int done_at = -1;
        int want = stall ? 15 : 12;
        do_reset();
        write_cfg(0, 32'h0010_0000);
        tick();
        write_cfg(2, 32'h0010_0000);
        write_cfg(3, 32'h0040_0000);
        sweep_dwell = 16'd4; enable = 1; sweep_start = 1;
        tick();
        sweep_start = 0;
        checks++;
        if ({sweep_busy, cfg_ready} !== 2'b10) begin
            errors++; $display("FAIL sweep start: got busy %b ready %b want 1 0", sweep_busy, cfg_ready);
        end
        for (int k = 1; k <= 25; k++) begin
            enable = !(stall && k >= 6 && k <= 8);
            tick();
            if (sweep_done === 1'b1 && done_at < 0) done_at = k;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL sweep k %0d: got %h want %h", k, obs, exp_vec());
            end
        end
        checks++;
        if (done_at != want) begin
            errors++; $display("FAIL sweep done cycle: got %0d want %0d", done_at, want);
        end
        checks++;
        if ({sweep_busy, sweep_done, cfg_ready} !== 3'b001) begin
            errors++; $display("FAIL sweep idle: got %b want 001", {sweep_busy, sweep_done, cfg_ready});
        end
    endtask

    task automatic test_carry();
        int done_at = -1;
        int d = int'($urandom_range(0, 3));
        int want = (d == 0) ? 1 : d;
        do_reset();
        write_cfg(0, 32'h9000_0000);
        tick();
        write_cfg(2, 32'h8000_0000);
        write_cfg(3, 32'hFFFF_FFFF);
        sweep_dwell = 16'(d); enable = 1; sweep_start = 1;
        tick();
        sweep_start = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (sweep_done === 1'b1 && done_at < 0) done_at = k;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL carry k %0d: got %h want %h", k, obs, exp_vec());
            end
        end
        checks++;
        if (done_at != want) begin
            errors++; $display("FAIL carry done cycle: got %0d want %0d", done_at, want);
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit seen = 0;
        do_reset();
        write_cfg(0, 32'h0010_0000);
        tick();
        write_cfg(2, 32'h0001_0000);
        write_cfg(3, 32'h0100_0000);
        sweep_dwell = 16'd8; enable = 1; sweep_start = 1;
        tick();
        sweep_start = 0;
        for (int i = 0; i < 5; i++) tick();
        reset_n = 0;
        tick();
        checks++;
        if (obs !== 16'h0001) begin
            errors++; $display("FAIL reset mid-sweep: got %h want %h", obs, 16'h0001);
        end
        reset_n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sweep_done === 1'b1) seen = 1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL post-reset cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL post-reset done pulse: got 1 want 0");
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            reset_n     = ($urandom_range(0, 199) != 0);
            enable      = ($urandom_range(0, 3) != 0);
            cfg_valid   = ($urandom_range(0, 4) == 0);
            cfg_sel     = 2'($urandom);
            cfg_data    = (cfg_sel == 2'd2) ? ($urandom >> $urandom_range(0, 8)) : $urandom;
            sweep_start = ($urandom_range(0, 29) == 0);
            sweep_dwell = 16'($urandom_range(0, 5));
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        reset_n = 1; cfg_valid = 0; sweep_start = 0;
    endtask

    initial begin
        reset_n = 0; enable = 0; cfg_valid = 0; cfg_sel = 0; cfg_data = 0;
        sweep_start = 0; sweep_dwell = 0;
        test_reset();
        test_basic();
        test_half();
        test_midrun();
        test_sweep(0);
        test_sweep(1);
        test_carry();
        test_reset_mid_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
